// File: rtl/hex_disp_pkg.sv
// Shared types and helpers for the BCD counter display: mode encoding,
// blank segment pattern and the 7-segment decoder.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Active-high pattern with nothing lit (DP included); polarity is applied at the output.
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Active-high segments, bit order g..a.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the counter chain; carry/borrow ripple to the next
// more significant cell in the same cycle.
module bcd_digit_cell (
    input  logic       clk_clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       load_i,
    input  logic [3:0] value_i,
    output logic [3:0] digit_o,
    output logic       carry_o,
    output logic       borrow_o
);

    logic [3:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = value_i;
        end else if (inc_i) begin
            digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end else if (dec_i) begin
            digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o  = digit_q;
    assign carry_o  = inc_i && (digit_q == 4'd9);
    assign borrow_o = dec_i && (digit_q == 4'd0);

endmodule

// File: rtl/hex_bcd_counter_display.sv
// N-digit BCD up/down/load counter with registered 7-segment drive.
// Optional leading-zero blanking when HEX_LZB_EN is defined.
//
//   state     | meaning
//   MODE_HOLD | count frozen, ticks ignored
//   MODE_UP   | increment on each tick
//   MODE_DOWN | decrement on each tick
//   MODE_LOAD | key press writes bcd_in into the selected digit, DP marks it
module hex_bcd_counter_display
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 5,
    parameter int CLK_HZ         = 50_000_000,
    parameter int SLOW_HZ        = 1,
    parameter int FAST_HZ        = 10,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                                                clk_clk,
    input  logic                                                reset_reset_n,
    input  logic [1:0]                                          mode_i,
    input  logic                                                speed_i,
    input  logic [3:0]                                          bcd_in,
    input  logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_sel_i,
    input  logic                                                load_i,
    output logic [8*NUM_DIGITS-1:0]                             seg_o,
    output logic [4*NUM_DIGITS-1:0]                             count_o,
    output logic                                                wrap_o
);

    localparam int SEL_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOW_PERIOD = CLK_HZ / SLOW_HZ;
    localparam int FAST_PERIOD = CLK_HZ / FAST_HZ;
    localparam int DIV_W       = (SLOW_PERIOD > 1) ? $clog2(SLOW_PERIOD) : 1;
    localparam logic [DIV_W-1:0] SLOW_TC = DIV_W'(SLOW_PERIOD - 1);
    localparam logic [DIV_W-1:0] FAST_TC = DIV_W'(FAST_PERIOD - 1);
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

    // mode_meta_q -> state_q forms the mode synchroniser.
    logic [1:0] mode_meta_q;
    mode_e      state_q, state_d;
    logic       speed_meta_q, speed_s_q, speed_prev_q;
    logic       load_meta_q, load_s_q, load_prev_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic       wrap_q, wrap_d;
    logic [8*NUM_DIGITS-1:0] seg_q, seg_d;
    logic       speed_chg, term_cnt, tick, press;
    logic [3:0] load_val;
    logic [NUM_DIGITS:0] carry, borrow;

    always_comb begin
        state_d   = mode_e'(mode_meta_q);
        speed_chg = (speed_s_q != speed_prev_q);
        term_cnt  = speed_s_q ? (div_q == FAST_TC) : (div_q == SLOW_TC);
        tick      = term_cnt && !speed_chg;
        div_d     = (term_cnt || speed_chg) ? '0 : div_q + 1'b1;
        press     = (state_q == MODE_LOAD) && load_prev_q && !load_s_q;
        load_val  = (bcd_in > 4'd9) ? 4'd9 : bcd_in;
        carry[0]  = tick && (state_q == MODE_UP);
        borrow[0] = tick && (state_q == MODE_DOWN);
        wrap_d    = carry[NUM_DIGITS] || borrow[NUM_DIGITS];
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk_clk  (clk_clk),
            .rst_n    (reset_reset_n),
            .inc_i    (carry[k]),
            .dec_i    (borrow[k]),
            .load_i   (press && (digit_sel_i == SEL_W'(k))),
            .value_i  (load_val),
            .digit_o  (count_o[4*k +: 4]),
            .carry_o  (carry[k+1]),
            .borrow_o (borrow[k+1])
        );
    end

    // Blanking walks down from the top digit; a shown digit ends the leading run.
    always_comb begin
        logic [7:0] raw;
        logic       sel_here;
`ifdef HEX_LZB_EN
        logic       lead_zero;
        lead_zero = 1'b1;
`endif
        seg_d    = '0;
        raw      = SEG_BLANK;
        sel_here = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            sel_here = (state_q == MODE_LOAD) && (digit_sel_i == SEL_W'(k));
            raw      = {sel_here, bcd_to_seg(count_o[4*k +: 4])};
`ifdef HEX_LZB_EN
            lead_zero = lead_zero && (count_o[4*k +: 4] == 4'd0) && !sel_here && (k != 0);
            if (lead_zero) begin
                raw = SEG_BLANK;
            end
`endif
            seg_d[8*k +: 8] = (SEG_ACTIVE_LOW != 0) ? ~raw : raw;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mode_meta_q  <= 2'b00;
            state_q      <= MODE_HOLD;
            speed_meta_q <= 1'b0;
            speed_s_q    <= 1'b0;
            speed_prev_q <= 1'b0;
            load_meta_q  <= 1'b1;
            load_s_q     <= 1'b1;
            load_prev_q  <= 1'b1;
            div_q        <= '0;
            wrap_q       <= 1'b0;
            seg_q        <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            mode_meta_q  <= mode_i;
            state_q      <= state_d;
            speed_meta_q <= speed_i;
            speed_s_q    <= speed_meta_q;
            speed_prev_q <= speed_s_q;
            load_meta_q  <= load_i;
            load_s_q     <= load_meta_q;
            load_prev_q  <= load_s_q;
            div_q        <= div_d;
            wrap_q       <= wrap_d;
            seg_q        <= seg_d;
        end
    end

    assign wrap_o = wrap_q;
    assign seg_o  = seg_q;

endmodule
